// File: rtl/memoria_pkg.sv
// Shared definitions for the FIFO access controller.
//   DATA_W_DEF     : default data width (matches the FIFO word)
//   CNT_W_DEF      : default width of the per-producer grant counters
//   estado_lect_t  : read-side sequencer states
package memoria_pkg;

   localparam int unsigned DATA_W_DEF = 16;
   localparam int unsigned CNT_W_DEF  = 16;

   typedef enum logic [1:0] {
      VACIO  = 2'd0,
      ESPERA = 2'd1,
      LLENO  = 2'd2
   } estado_lect_t;

endpackage

// File: rtl/arbitro_rr.sv
// Two-input round-robin arbiter with a registered priority pointer.
//   clk, rst : clock, asynchronous active-high reset
//   req      : request per input
//   bloqueo  : suppresses every grant (target cannot accept)
//   gnt      : one-hot grant, combinational from req and the pointer
module arbitro_rr
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       bloqueo,
   output logic [1:0] gnt
);

   logic prio_q, prio_d;

   always_comb begin
      gnt = 2'b00;
      if (!bloqueo && !rst) begin
         unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = prio_q ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
         endcase
      end
   end

   // Pointer moves to the loser after any grant, even without contention.
   always_comb begin
      prio_d = prio_q;
      if (gnt[0]) begin
         prio_d = 1'b1;
      end else if (gnt[1]) begin
         prio_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prio_q <= 1'b0;
      end else begin
         prio_q <= prio_d;
      end
   end

endmodule

// File: rtl/arbitro_memoria.sv
// Shares one synchronous FIFO between two write producers and one read consumer.
// Write side: round-robin arbitration, valid/ack with zero latency.
// Read side: sequences rd_en around the FIFO's one-cycle read latency and
// presents the word on a valid/ready interface.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   req0/dato0/ack0          : producer 0 handshake
//   req1/dato1/ack1          : producer 1 handshake
//   fifo_din/fifo_wr_en      : FIFO write port
//   fifo_rd_en/fifo_dout     : FIFO read port (dout valid one cycle after rd_en)
//   fifo_full/fifo_empty     : FIFO flags
//   out_dato/out_valid/out_ready : consumer interface
//   cnt0/cnt1                : saturating grant counters (ARB_ESTADISTICAS_EN only)
// Optional feature macro: ARB_ESTADISTICAS_EN.
module arbitro_memoria
   import memoria_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned CNT_W  = CNT_W_DEF
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic [DATA_W-1:0] dato0,
   output logic              ack0,
   input  logic              req1,
   input  logic [DATA_W-1:0] dato1,
   output logic              ack1,
   output logic [DATA_W-1:0] fifo_din,
   output logic              fifo_wr_en,
   output logic              fifo_rd_en,
   input  logic [DATA_W-1:0] fifo_dout,
   input  logic              fifo_full,
   input  logic              fifo_empty,
   output logic [DATA_W-1:0] out_dato,
   output logic              out_valid,
   input  logic              out_ready
`ifdef ARB_ESTADISTICAS_EN
   ,
   output logic [CNT_W-1:0]  cnt0,
   output logic [CNT_W-1:0]  cnt1
`endif
);

   // ---------------- Write side ----------------
   logic [1:0] gnt;

   arbitro_rr u_arbitro_rr (
      .clk     (clk),
      .rst     (rst),
      .req     ({req1, req0}),
      .bloqueo (fifo_full),
      .gnt     (gnt)
   );

   // The arbiter already gates grants with rst.
   assign ack0       = gnt[0];
   assign ack1       = gnt[1];
   assign fifo_wr_en = gnt[0] | gnt[1];
   assign fifo_din   = gnt[1] ? dato1 : dato0;

   // ---------------- Read side ----------------
   estado_lect_t      estado_q, estado_d;
   logic [DATA_W-1:0] out_dato_q, out_dato_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         estado_q   <= VACIO;
         out_dato_q <= '0;
      end else begin
         estado_q   <= estado_d;
         out_dato_q <= out_dato_d;
      end
   end

   always_comb begin
      estado_d   = estado_q;
      out_dato_d = out_dato_q;
      unique case (estado_q)
         VACIO: begin
            if (!fifo_empty) estado_d = ESPERA;
         end
         ESPERA: begin
            // FIFO dout is valid now, one cycle after rd_en.
            out_dato_d = fifo_dout;
            estado_d   = LLENO;
         end
         LLENO: begin
            if (out_ready) estado_d = fifo_empty ? VACIO : ESPERA;
         end
         default: estado_d = VACIO;
      endcase
   end

   // Mealy read enable: issue only when the FIFO reports data right now.
   always_comb begin
      fifo_rd_en = 1'b0;
      if (!rst && !fifo_empty) begin
         unique case (estado_q)
            VACIO:   fifo_rd_en = 1'b1;
            LLENO:   fifo_rd_en = out_ready;
            default: fifo_rd_en = 1'b0;
         endcase
      end
   end

   assign out_valid = (estado_q == LLENO);
   assign out_dato  = out_dato_q;

`ifdef ARB_ESTADISTICAS_EN
   // ---------------- Grant statistics ----------------
   logic [CNT_W-1:0] cnt0_q, cnt1_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         if (ack0 && (cnt0_q != {CNT_W{1'b1}})) cnt0_q <= cnt0_q + CNT_W'(1);
         if (ack1 && (cnt1_q != {CNT_W{1'b1}})) cnt1_q <= cnt1_q + CNT_W'(1);
      end
   end

   assign cnt0 = cnt0_q;
   assign cnt1 = cnt1_q;
`endif

endmodule
